// File: rtl/dpram_fifo_ctrl.sv
// FIFO controller that turns a dual-port RAM (port A write, port B read) into a FIFO.
// Latency: a pushed word can be popped from the next cycle; rd_valid/rd_data follow an accepted pop by one cycle.
// Backpressure: push is refused while full (overflow sticks), pop is refused while empty (underflow sticks).
//
// Ports:
//   clk, reset                       rising-edge clock, synchronous active-high reset
//   wr_en, wr_data, full             push side
//   rd_en, rd_data, rd_valid, empty  pop side; rd_data holds its last value when rd_valid is low
//   count, overflow, underflow       occupancy (0..DEPTH) and sticky error flags
//   ram_*                            connections to the dual-port RAM (A = write, B = read)
module dpram_fifo_ctrl #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  wr_en,
   input  logic [DATA_WIDTH-1:0] wr_data,
   output logic                  full,
   input  logic                  rd_en,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic                  rd_valid,
   output logic                  empty,
   output logic [ADDR_WIDTH:0]   count,
   output logic                  overflow,
   output logic                  underflow,
   output logic                  ram_write_en_a,
   output logic [ADDR_WIDTH-1:0] ram_address_a,
   output logic [DATA_WIDTH-1:0] ram_data_in_a,
   output logic                  ram_write_en_b,
   output logic [ADDR_WIDTH-1:0] ram_address_b,
   output logic [DATA_WIDTH-1:0] ram_data_in_b,
   input  logic [DATA_WIDTH-1:0] ram_data_out_b
);

   // Count value meaning "full" (DEPTH = 2**ADDR_WIDTH, needs the extra MSB).
   localparam logic [ADDR_WIDTH:0]   CNT_FULL = {1'b1, {ADDR_WIDTH{1'b0}}};
   localparam logic [ADDR_WIDTH:0]   CNT_ONE  = (ADDR_WIDTH+1)'(1);
   localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = ADDR_WIDTH'(1);

   logic [ADDR_WIDTH-1:0] wr_ptr;
   logic [ADDR_WIDTH-1:0] rd_ptr;
   logic [ADDR_WIDTH:0]   count_q;
   logic [DATA_WIDTH-1:0] rd_hold;
   logic                  push_ok;
   logic                  pop_ok;

   assign empty   = (count_q == '0);
   assign full    = (count_q == CNT_FULL);
   assign count   = count_q;
   assign push_ok = wr_en & ~full;
   assign pop_ok  = rd_en & ~empty;

   // Write path: the RAM must never see a write while reset is asserted.
   assign ram_write_en_a = push_ok & ~reset;
   assign ram_address_a  = wr_ptr;
   assign ram_data_in_a  = wr_data;

   // Read path: the RAM samples rd_ptr every edge, so on the edge that accepts a
   // pop it captures the head word, which is on data_out_b in the following cycle.
   assign ram_write_en_b = 1'b0;
   assign ram_address_b  = rd_ptr;
   assign ram_data_in_b  = '0;

   // data_out_b keeps changing as rd_ptr moves, so the last popped word is
   // captured to present a stable rd_data between pops.
   assign rd_data = rd_valid ? ram_data_out_b : rd_hold;

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count_q   <= '0;
         rd_valid  <= 1'b0;
         rd_hold   <= '0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         if (push_ok) begin
            wr_ptr <= wr_ptr + PTR_ONE;
         end
         if (pop_ok) begin
            rd_ptr <= rd_ptr + PTR_ONE;
         end
         rd_valid <= pop_ok;
         if (rd_valid) begin
            rd_hold <= ram_data_out_b;
         end
         case ({push_ok, pop_ok})
            2'b10:   count_q <= count_q + CNT_ONE;
            2'b01:   count_q <= count_q - CNT_ONE;
            default: count_q <= count_q;
         endcase
         if (wr_en & full) begin
            overflow <= 1'b1;
         end
         if (rd_en & empty) begin
            underflow <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_dpram_fifo_ctrl.sv
module tb_dpram_fifo_ctrl;

   localparam int DW    = 8;
   localparam int AW    = 8;
   localparam int DEPTH = 256;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          wr_en = 1'b0;
   logic [DW-1:0] wr_data = '0;
   logic          full;
   logic          rd_en = 1'b0;
   logic [DW-1:0] rd_data;
   logic          rd_valid;
   logic          empty;
   logic [AW:0]   count;
   logic          overflow;
   logic          underflow;
   logic          ram_write_en_a;
   logic [AW-1:0] ram_address_a;
   logic [DW-1:0] ram_data_in_a;
   logic          ram_write_en_b;
   logic [AW-1:0] ram_address_b;
   logic [DW-1:0] ram_data_in_b;
   logic [DW-1:0] ram_data_out_b = '0;

   always #5 clk = ~clk;

   dpram_fifo_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
      .clk            (clk),
      .reset          (reset),
      .wr_en          (wr_en),
      .wr_data        (wr_data),
      .full           (full),
      .rd_en          (rd_en),
      .rd_data        (rd_data),
      .rd_valid       (rd_valid),
      .empty          (empty),
      .count          (count),
      .overflow       (overflow),
      .underflow      (underflow),
      .ram_write_en_a (ram_write_en_a),
      .ram_address_a  (ram_address_a),
      .ram_data_in_a  (ram_data_in_a),
      .ram_write_en_b (ram_write_en_b),
      .ram_address_b  (ram_address_b),
      .ram_data_in_b  (ram_data_in_b),
      .ram_data_out_b (ram_data_out_b)
   );

   // Behavioural dual-port RAM: synchronous write on A, registered read on B.
   logic [DW-1:0] mem [DEPTH];
   always @(posedge clk) begin
      if (ram_write_en_a) mem[ram_address_a] <= ram_data_in_a;
      ram_data_out_b <= mem[ram_address_b];
   end

   int n_checks = 0;
   int n_errors = 0;

   // Reference model state
   logic [DW-1:0] sb_q[$];
   int            m_count = 0;
   int            m_wr_ptr = 0;
   int            m_rd_ptr = 0;
   logic          m_ovf = 1'b0;
   logic          m_unf = 1'b0;
   logic          m_valid = 1'b0;
   logic [DW-1:0] m_last = '0;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
      end
   endtask

   task automatic post_checks();
      chk("count",     32'(count),          32'(m_count));
      chk("empty",     32'(empty),          32'(m_count == 0));
      chk("full",      32'(full),           32'(m_count == DEPTH));
      chk("rd_valid",  32'(rd_valid),       32'(m_valid));
      chk("rd_data",   32'(rd_data),        32'(m_last));
      chk("overflow",  32'(overflow),       32'(m_ovf));
      chk("underflow", 32'(underflow),      32'(m_unf));
      chk("addr_b",    32'(ram_address_b),  32'(m_rd_ptr));
      chk("we_b",      32'(ram_write_en_b), 32'(0));
      chk("din_b",     32'(ram_data_in_b),  32'(0));
   endtask

   // One clock cycle of stimulus; called just after a rising edge.
   task automatic cycle(input logic w, input logic [DW-1:0] d, input logic r);
      logic push_ok, pop_ok;
      wr_en = w; wr_data = d; rd_en = r;
      #1;
      push_ok = w && (m_count != DEPTH);
      pop_ok  = r && (m_count != 0);
      chk("we_a", 32'(ram_write_en_a), 32'(push_ok));
      if (push_ok) begin
         chk("addr_a", 32'(ram_address_a), 32'(m_wr_ptr));
         chk("din_a",  32'(ram_data_in_a), 32'(d));
      end
      @(posedge clk);
      if (w && !push_ok) m_ovf = 1'b1;
      if (r && !pop_ok)  m_unf = 1'b1;
      m_valid = pop_ok;
      if (pop_ok) begin
         m_last = sb_q.pop_front();
         m_rd_ptr = (m_rd_ptr + 1) % DEPTH;
      end
      if (push_ok) begin
         sb_q.push_back(d);
         m_wr_ptr = (m_wr_ptr + 1) % DEPTH;
      end
      m_count = m_count + (push_ok ? 1 : 0) - (pop_ok ? 1 : 0);
      #1;
      post_checks();
   endtask

   task automatic do_reset(input logic w, input logic r);
      reset = 1'b1; wr_en = w; wr_data = 8'hEE; rd_en = r;
      #1;
      chk("we_a_in_reset", 32'(ram_write_en_a), 32'(0));
      @(posedge clk);
      sb_q.delete();
      m_count = 0; m_wr_ptr = 0; m_rd_ptr = 0;
      m_ovf = 1'b0; m_unf = 1'b0; m_valid = 1'b0; m_last = '0;
      #1;
      reset = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
      post_checks();
   endtask

   initial begin
      // Reset then idle
      do_reset(1'b0, 1'b0);
      for (int i = 0; i < 3; i++) cycle(1'b0, 8'h00, 1'b0);

      // Three pushes then three pops
      cycle(1'b1, 8'h01, 1'b0);
      cycle(1'b1, 8'h02, 1'b0);
      cycle(1'b1, 8'h03, 1'b0);
      for (int i = 0; i < 3; i++) cycle(1'b0, 8'h00, 1'b1);
      cycle(1'b0, 8'h00, 1'b0);

      // Fill completely, overflow attempt, drain
      for (int i = 0; i < DEPTH; i++) cycle(1'b1, 8'(i), 1'b0);
      cycle(1'b1, 8'hAA, 1'b0);
      for (int i = 0; i < DEPTH; i++) cycle(1'b0, 8'h00, 1'b1);
      cycle(1'b0, 8'h00, 1'b0);

      // Underflow, then push with rd_en held: no same-cycle bypass
      cycle(1'b0, 8'h00, 1'b1);
      cycle(1'b1, 8'h55, 1'b1);
      cycle(1'b0, 8'h00, 1'b1);
      cycle(1'b0, 8'h00, 1'b0);

      // Fill to 200, then steady-state push+pop across pointer wrap, then drain
      for (int i = 0; i < 200; i++) cycle(1'b1, 8'($urandom_range(0, 255)), 1'b0);
      for (int i = 0; i < 300; i++) cycle(1'b1, 8'($urandom_range(0, 255)), 1'b1);
      for (int i = 0; i < 200; i++) cycle(1'b0, 8'h00, 1'b1);
      cycle(1'b0, 8'h00, 1'b0);

      // Reset in the middle of activity
      for (int i = 0; i < 5; i++) cycle(1'b1, 8'(8'h10 + i), 1'b0);
      cycle(1'b0, 8'h00, 1'b1);
      do_reset(1'b1, 1'b1);
      cycle(1'b1, 8'h77, 1'b0);
      cycle(1'b0, 8'h00, 1'b1);
      cycle(1'b0, 8'h00, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
